symbol_encoder: RTL and testbench
=================================

# symbol_encoder

Transmit-side counterpart of the line decoder. Accepts 4-bit symbols over a valid/ready stream, buffers them in a small FIFO, and serializes each one onto the single-wire `signal` output as a pulse-width-coded frame that the existing decoder recovers. Sits between the UART receive path, which supplies the nibbles, and the physical modulator output pin.

## Interface
- `BIT_CYCLES`, default 1000: clocks per bit period. Must be ≥ 4.
- `GAP_BITS`, default 2: idle-low bit periods appended after each frame. Must be ≥ 1.
- `FIFO_DEPTH`, default 4: symbol buffer depth. Must be a power of 2 and ≥ 2.
- `clk` in, 1: single clock. All logic is on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `din` in, 4: symbol to transmit.
- `din_valid` in, 1: `din` is valid.
- `din_ready` out, 1: FIFO can accept a word. Equals `!full`, taken from registered count.
- `signal` out, 1: encoded line output. Registered.
- `busy` out, 1: high whenever the FSM is not in IDLE. Registered.
- `fifo_count` out, $clog2(FIFO_DEPTH)+1: number of words buffered.

## Operation
- **Reset values:** `signal`=0, `busy`=0, `fifo_count`=0, `din_ready`=1. FSM is in IDLE and all counters are 0.
- **Push:** a word is written when `din_valid && din_ready` at a rising edge. When full, `din_ready`=0 and `din` is ignored.
- **Pop:** performed only by the FSM at frame start. A push and a pop in the same cycle leave `fifo_count` unchanged.
- **FSM states:** IDLE → START → DATA → GAP → (START | IDLE).
  - **IDLE:** `signal`=0. If the FIFO is not empty: pop into a 4-bit shift register, then go to START.
  - **START:** `signal`=1 for BIT_CYCLES clocks, then go to DATA.
  - **DATA:** sends 4 bits, MSB first, each BIT_CYCLES clocks long.
    - Bit counter `cnt` runs 0..BIT_CYCLES-1.
    - Bit=1: `signal`=1 while `cnt` < HI1, where HI1 = (3*BIT_CYCLES)/4, integer division.
    - Bit=0: `signal`=1 while `cnt` < HI0, where HI0 = BIT_CYCLES/4.
    - Otherwise `signal`=0.
    - After the 4th bit, go to GAP.
  - **GAP:** `signal`=0 for GAP_BITS*BIT_CYCLES clocks. On the last GAP cycle:
    - FIFO not empty: pop and go directly to START, with no idle cycle between frames.
    - FIFO empty: go to IDLE.
- **Frame length:** exactly (5+GAP_BITS)*BIT_CYCLES clocks.
- **Counters:** the cycle counter is sized $clog2(GAP_BITS*BIT_CYCLES) bits and never wraps inside a state. It is cleared on every state change and every bit boundary.
- **Shift register:** holds the popped symbol for the whole frame. New pushes never disturb a frame in progress.
- **`signal` computation:** computed from next-state and next-count, then registered, so it is glitch-free.

## Timing
- **Idle-to-frame latency:** word pushed into an empty FIFO at edge E while in IDLE:
  - pop at edge E+1;
  - `signal`=1 and `busy`=1 visible after E+1.
- **Start pulse:** `signal` stays high for exactly BIT_CYCLES cycles.
- **Data bits:** bit k (k=0 is din[3]) begins BIT_CYCLES*(1+k) cycles after `signal` rises.
- **Back-to-back frames:** the next start pulse begins the cycle after the last GAP cycle.
- **`busy` timing:** `busy` falls on the same edge the FSM enters IDLE.
- **`din_ready`:** falls on the edge where `fifo_count` reaches FIFO_DEPTH. It rises the edge after a pop from full.
- **Reset mid-frame:** on `rst` assertion, `signal` goes to 0 immediately (asynchronous), the FIFO empties, and the frame is abandoned. After release, the block waits in IDLE for new pushes.

## Test plan
Bench parameters: BIT_CYCLES=8, GAP_BITS=2, FIFO_DEPTH=4.
- **Single symbol:** push 4'hA while idle. Required response, one edge after the push:
  - `signal` pattern H8, then H6 L2, H2 L6, H6 L2, H2 L6, then L16;
  - `busy` high for 56 cycles, then low.
- **Bit extremes:**
  - push 4'h0 → H8, then (H2 L6)×4, then L16;
  - push 4'hF → H8, then (H6 L2)×4, then L16.
- **Back-to-back:** push 4'h3 and 4'hC on consecutive cycles. Required response:
  - two frames with no gap beyond the 16 GAP cycles;
  - second start pulse begins 56 cycles after the first;
  - `busy` stays high for 112 cycles.
- **Full FIFO:** hold `din_valid`=1 with 4'h1..4'h6 while idle. Required response:
  - first word popped;
  - `fifo_count` saturates at 4 and `din_ready`=0;
  - words 4'h1 through 4'h5 are transmitted in order and 4'h6 is accepted only after the next pop;
  - no word is lost or duplicated.
- **Reset mid-frame:** assert `rst` during DATA bit 2 of 4'h9 with 2 words queued. Required response:
  - `signal`=0 immediately;
  - `fifo_count`=0;
  - `busy`=0;
  - after release, no output until a new push, and a pushed 4'h5 then produces a clean frame.

Source files
------------

// File: rtl/symbol_encoder_if.sv
// symbol_encoder_if
//   Valid/ready stream that carries 4-bit symbols into the symbol encoder.
//   Signals:
//     din       - symbol to transmit (producer -> encoder)
//     din_valid - din holds a valid symbol (producer -> encoder)
//     din_ready - encoder can accept a symbol this cycle (encoder -> producer)
//   Modports:
//     master - symbol producer (e.g. UART receive path)
//     slave  - symbol encoder
interface symbol_encoder_if;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/symbol_encoder.sv
// symbol_encoder
//   Buffers 4-bit symbols in a small FIFO and serializes each one onto the
//   single-wire line output as a pulse-width-coded frame:
//     start pulse (high for one bit period), four data bits MSB first
//     (long pulse = 1, short pulse = 0), then GAP_BITS idle-low bit periods.
//   Parameters:
//     BIT_CYCLES - clocks per bit period (>= 4)
//     GAP_BITS   - idle-low bit periods after each frame (>= 1)
//     FIFO_DEPTH - symbol buffer depth (power of 2, >= 2)
//   Ports:
//     clk        - clock, rising edge
//     rst        - asynchronous active-high reset
//     din_bus    - symbol input stream (slave side of symbol_encoder_if)
//     signal     - registered encoded line output
//     busy       - registered, high whenever the FSM is not idle
//     fifo_count - number of symbols currently buffered
module symbol_encoder #(
  parameter int BIT_CYCLES = 1000,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  symbol_encoder_if.slave               din_bus,
  output logic                          signal,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = AW + 1;
  localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  // The gap is the longest state, so sizing for it covers every state.
  localparam int CNT_W      = $clog2(GAP_CYCLES);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI1      = CNT_W'((3 * BIT_CYCLES) / 4);
  localparam logic [CNT_W-1:0] HI0      = CNT_W'(BIT_CYCLES / 4);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Symbol FIFO
  // ---------------------------------------------------------------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign fifo_full         = (count_reg == FULL_CNT);
  assign fifo_empty        = (count_reg == '0);
  assign din_bus.din_ready = !fifo_full;
  assign push              = din_bus.din_valid && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din_bus.din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      // Simultaneous push and pop cancel out.
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t           state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [1:0]       bit_reg,    bit_next;
  logic [3:0]       sym_reg,    sym_next;
  logic             signal_reg, signal_next;
  logic             data_bit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    pop        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == BIT_LAST) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = 2'd0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (bit_reg == 2'd3) begin
            state_next = GAP;
          end else begin
            bit_next = bit_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          // Chain straight into the next frame when more symbols wait.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // The symbol is captured only at frame start and held for the frame.
    sym_next = pop ? mem[rd_ptr_reg] : sym_reg;

    // Bit index 0 carries the MSB, so ~bit_next (= 3 - bit_next) selects it.
    data_bit = sym_next[~bit_next];

    // Line level is derived from the upcoming state/count and then
    // registered, so the pin never sees combinational glitches.
    signal_next = 1'b0;
    case (state_next)
      START:   signal_next = 1'b1;
      DATA:    signal_next = data_bit ? (cnt_next < HI1) : (cnt_next < HI0);
      default: signal_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      sym_reg    <= '0;
      signal_reg <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      sym_reg    <= sym_next;
      signal_reg <= signal_next;
      busy       <= (state_next != IDLE);
    end
  end

  assign signal     = signal_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_symbol_encoder.sv
// tb_symbol_encoder
//   Self-checking bench for symbol_encoder with BIT_CYCLES=8, GAP_BITS=2,
//   FIFO_DEPTH=4. Each accepted symbol pushes its expected frame description
//   onto a scoreboard queue; a line monitor captures every frame on `signal`
//   and compares it sample by sample against the expected waveform.
module tb_symbol_encoder;

  localparam int BC    = 8;
  localparam int GB    = 2;
  localparam int FD    = 4;
  localparam int FRAME = (5 + GB) * BC;

  typedef struct {
    logic [3:0] sym;
    int         h0;  // expected high cycles in data bit 0 (din[3])
    int         h1;
    int         h2;
    int         h3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       signal;
  logic       busy;
  logic [2:0] fifo_count;

  symbol_encoder_if bus ();

  symbol_encoder #(
    .BIT_CYCLES(BC),
    .GAP_BITS  (GB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_bus   (bus),
    .signal    (signal),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  vec_t tbl [16];
  vec_t sb [$];
  int   rises [$];
  bit   frame_samp [FRAME];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit exp_sample(input vec_t v, input int i);
    int seg;
    int off;
    seg = i / BC;
    off = i % BC;
    case (seg)
      0:       return 1'b1;
      1:       return off < v.h0;
      2:       return off < v.h1;
      3:       return off < v.h2;
      4:       return off < v.h3;
      default: return 1'b0;
    endcase
  endfunction

  task automatic eval_frame();
    vec_t v;
    int   mism;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 1, 0);
    end else begin
      v    = sb.pop_front();
      mism = 0;
      for (int i = 0; i < FRAME; i++)
        if (frame_samp[i] != exp_sample(v, i)) mism++;
      chk($sformatf("frame_%h_mismatched_samples", v.sym), mism, 0);
      $display("frame sym=%h mismatched_samples=%0d", v.sym, mism);
    end
  endtask

  // Line monitor: a rising edge outside a frame starts a FRAME-sample capture.
  initial begin : monitor
    int idx;
    bit prev;
    idx  = -1;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idx  = -1;
        prev = 1'b0;
      end else begin
        if (idx < 0 && signal && !prev) begin
          idx = 0;
          rises.push_back(cyc);
        end
        if (idx >= 0) begin
          frame_samp[idx] = signal;
          idx++;
          if (idx == FRAME) begin
            eval_frame();
            idx = -1;
          end
        end
        prev = signal;
      end
    end
  end

  // Returns just after the accepting edge (edge E + 1 ns).
  task automatic push_one(input logic [3:0] s);
    int k;
    @(negedge clk);
    bus.din       = s;
    bus.din_valid = 1'b1;
    k = 0;
    while (!bus.din_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    if (k >= 500) chk($sformatf("push_%h_timeout", s), 1, 0);
    else begin
      sb.push_back(tbl[s]);
      $display("push sym=%h fifo_count=%0d", s, fifo_count);
    end
  endtask

  // Called just after the edge where busy should first be high.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_busy_after_drain"}, int'(busy), 0);
    chk({name, "_scoreboard_left"}, sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] vlist [4];
    int n;
    int r0;
    int hi_seen;

    tbl[4'h0] = '{4'h0, 2, 2, 2, 2};
    tbl[4'h1] = '{4'h1, 2, 2, 2, 6};
    tbl[4'h2] = '{4'h2, 2, 2, 6, 2};
    tbl[4'h3] = '{4'h3, 2, 2, 6, 6};
    tbl[4'h4] = '{4'h4, 2, 6, 2, 2};
    tbl[4'h5] = '{4'h5, 2, 6, 2, 6};
    tbl[4'h6] = '{4'h6, 2, 6, 6, 2};
    tbl[4'h7] = '{4'h7, 2, 6, 6, 6};
    tbl[4'h8] = '{4'h8, 6, 2, 2, 2};
    tbl[4'h9] = '{4'h9, 6, 2, 2, 6};
    tbl[4'hA] = '{4'hA, 6, 2, 6, 2};
    tbl[4'hB] = '{4'hB, 6, 2, 6, 6};
    tbl[4'hC] = '{4'hC, 6, 6, 2, 2};
    tbl[4'hD] = '{4'hD, 6, 6, 2, 6};
    tbl[4'hE] = '{4'hE, 6, 6, 6, 2};
    tbl[4'hF] = '{4'hF, 6, 6, 6, 6};
    vlist[0] = 4'hA;
    vlist[1] = 4'h0;
    vlist[2] = 4'hF;
    vlist[3] = 4'h6;

    bus.din       = 4'h0;
    bus.din_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_signal", int'(signal), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fifo_count", int'(fifo_count), 0);
    chk("reset_din_ready", int'(bus.din_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single symbols from the vector table
    for (int i = 0; i < 4; i++) begin
      push_one(vlist[i]);
      chk($sformatf("sym_%h_signal_at_push_edge", vlist[i]), int'(signal), 0);
      @(posedge clk);
      #1;
      chk($sformatf("sym_%h_signal_after_E1", vlist[i]), int'(signal), 1);
      chk($sformatf("sym_%h_busy_after_E1", vlist[i]), int'(busy), 1);
      busy_len(n);
      chk($sformatf("sym_%h_busy_cycles", vlist[i]), n, FRAME);
      wait_idle($sformatf("sym_%h", vlist[i]), 200);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames
    r0 = rises.size();
    push_one(4'h3);
    push_one(4'hC);
    chk("b2b_busy_after_E1", int'(busy), 1);
    busy_len(n);
    chk("b2b_busy_cycles", n, 2 * FRAME);
    wait_idle("b2b", 300);
    chk("b2b_frames_seen", rises.size() - r0, 2);
    if (rises.size() - r0 == 2)
      chk("b2b_start_spacing", rises[r0 + 1] - rises[r0], FRAME);
    repeat (3) @(negedge clk);

    // Full FIFO: 1..5 back to back, 6 must wait for the next pop
    r0 = rises.size();
    push_one(4'h1);
    push_one(4'h2);
    chk("full_count_after_first_pop", int'(fifo_count), 1);
    push_one(4'h3);
    push_one(4'h4);
    push_one(4'h5);
    chk("full_fifo_count", int'(fifo_count), 4);
    chk("full_din_ready", int'(bus.din_ready), 0);
    push_one(4'h6);
    chk("full_word6_after_second_start", rises.size() - r0, 2);
    chk("full_count_after_word6", int'(fifo_count), 4);
    wait_idle("full", 6 * FRAME + 200);
    chk("full_frames_seen", rises.size() - r0, 6);
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 2 of 4'h9 with two words queued
    push_one(4'h9);
    push_one(4'h7);
    push_one(4'hB);
    chk("rst_pre_fifo_count", int'(fifo_count), 2);
    chk("rst_pre_busy", int'(busy), 1);
    repeat (24) @(posedge clk);
    #3;
    chk("rst_pre_signal_bit2", int'(signal), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_signal", int'(signal), 0);
    chk("rst_async_fifo_count", int'(fifo_count), 0);
    chk("rst_async_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (signal || busy) hi_seen++;
    end
    chk("rst_quiet_after_release", hi_seen, 0);
    chk("rst_count_after_release", int'(fifo_count), 0);
    push_one(4'h5);
    @(posedge clk);
    #1;
    chk("rst_new_frame_signal", int'(signal), 1);
    busy_len(n);
    chk("rst_new_frame_busy_cycles", n, FRAME);
    wait_idle("rst_new_frame", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
